unidade_de_controle_multiciclo: RTL and testbench

Parametrised multi-cycle control sequencer for the iZero CPU. It replaces single-cycle decode with an FSM that steps each instruction through fetch, decode, execute, memory and write-back, stretches multi-cycle ALU operations, and takes prioritised, maskable interrupts at instruction boundaries with an acknowledge handshake. It sits between the instruction register and the datapath; ALU function decoding stays in the ALU-control block, driven by the `aluStart` strobe.

---
 rtl/unidade_de_controle_multiciclo_if.sv | 54 +++++
 rtl/unidade_de_controle_multiciclo.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_unidade_de_controle_multiciclo.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_de_controle_multiciclo_if.sv
// -----------------------------------------------------------------------------
// unidade_de_controle_multiciclo_if
// Bundle between the instruction register / datapath and the multi-cycle
// control sequencer of the iZero CPU.
//
// Handshake: none of these signals carry a valid/ready pair. Inputs (op, func,
// isFalse, intr) are levels sampled on the rising clock edge; every output is
// a level that is meaningful in the cycle it is asserted. inta/intrId form the
// interrupt acknowledge: inta is high for exactly one cycle and intrId names
// the line being acknowledged in that same cycle.
//
// Modports:
//   master - instruction register / datapath side (drives op, func, isFalse,
//            intr; observes the control strobes)
//   slave  - control sequencer side (the reverse)
// -----------------------------------------------------------------------------
interface unidade_de_controle_multiciclo_if #(
  parameter int OP_WIDTH   = 6,
  parameter int FUNC_WIDTH = 6,
  parameter int IRQ_LINES  = 4,
  parameter int IRQ_ID_W   = 2
);
  logic [OP_WIDTH-1:0]   op;
  logic [FUNC_WIDTH-1:0] func;
  logic                  isFalse;
  logic [IRQ_LINES-1:0]  intr;

  logic                  irWrite;
  logic                  pcWrite;
  logic [1:0]            pcSource;
  logic                  regWrite;
  logic [1:0]            regDest;
  logic [1:0]            regWrtSelect;
  logic                  memWrite;
  logic                  aluStart;
  logic                  inta;
  logic [IRQ_ID_W-1:0]   intrId;
  logic                  userMode;
  logic                  kernelMode;
  logic                  isHalt;
  logic                  busy;

  modport master (
    output op, func, isFalse, intr,
    input  irWrite, pcWrite, pcSource, regWrite, regDest, regWrtSelect,
           memWrite, aluStart, inta, intrId, userMode, kernelMode, isHalt, busy
  );

  modport slave (
    input  op, func, isFalse, intr,
    output irWrite, pcWrite, pcSource, regWrite, regDest, regWrtSelect,
           memWrite, aluStart, inta, intrId, userMode, kernelMode, isHalt, busy
  );
endinterface

// File: rtl/unidade_de_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// unidade_de_controle_multiciclo
// Multi-cycle control sequencer for the iZero CPU. Steps each instruction
// through BUSCA (fetch), DECOD, EXEC, ESPERA (mul/div/mod stretch), MEM and
// ESCRITA (write-back), and takes prioritised interrupts at instruction
// boundaries while in user mode through a one-cycle INTR state.
//
// Ports:
//   clock        - system clock, rising edge
//   reset        - asynchronous, active-high reset
//   bus          - slave side of unidade_de_controle_multiciclo_if
//                  (op/func/isFalse/intr in, control strobes out)
//   o_dbg_state  - current FSM state encoding, for observation only
//
// Opcode map (decimal). op 0 is the R-type group, decoded by func:
//   func 2/3/4 mul/div/mod, func 18 jr, any other func is an ALU op.
// I-type: 3/4/5 mul/div/mod immediate; 1, 2, 6..14 arithmetic/logic
// immediates; 16 li, 17 la, 19 mov; 15 lw; 18 sw; 21 jf; 31 syscall;
// 32 exec; 60 j; 62 jal; 63 halt. Everything else behaves as a nop.
// -----------------------------------------------------------------------------
module unidade_de_controle_multiciclo #(
  parameter int OP_WIDTH   = 6,
  parameter int FUNC_WIDTH = 6,
  parameter int MULDIV_LAT = 4,
  parameter int IRQ_LINES  = 4,
  parameter int IRQ_ID_W   = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  unidade_de_controle_multiciclo_if.slave    bus,
  output logic [2:0]                         o_dbg_state
);

  typedef enum logic [2:0] {
    S_BUSCA, S_DECOD, S_EXEC, S_ESPERA, S_MEM, S_ESCRITA, S_INTR, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU, CL_MULDIV, CL_LW, CL_SW, CL_J, CL_JAL, CL_JR, CL_JF,
    CL_SYSCALL, CL_EXEC, CL_HALT
  } class_t;

  // Counter holds 0..MULDIV_LAT-2 while in ESPERA.
  localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0);

  state_t               r_state;
  class_t               r_class;
  logic                 r_rtype;
  logic [CNT_W-1:0]     r_cnt;
  logic [IRQ_LINES-1:0] r_pend;
  logic                 r_user;

  state_t               w_next;
  state_t               w_done;
  class_t               w_class;
  logic                 w_rtype;
  logic [31:0]          w_op_n;
  logic [31:0]          w_func_n;
  logic                 w_user_next;
  logic [IRQ_ID_W-1:0]  w_low;
  logic [IRQ_LINES-1:0] w_ack_mask;
  logic [IRQ_LINES-1:0] w_pend_next;

  logic                 w_irWrite;
  logic                 w_pcWrite;
  logic [1:0]           w_pcSource;
  logic                 w_regWrite;
  logic [1:0]           w_regDest;
  logic [1:0]           w_regWrtSelect;
  logic                 w_memWrite;
  logic                 w_aluStart;
  logic                 w_inta;
  logic [IRQ_ID_W-1:0]  w_intrId;
  logic                 w_isHalt;

  assign w_op_n   = 32'(bus.op);
  assign w_func_n = 32'(bus.func);

  // Instruction class from the live instruction register; only captured in DECOD.
  always_comb begin
    w_class = CL_NOP;
    w_rtype = (w_op_n == 32'd0);
    if (w_rtype) begin
      case (w_func_n)
        32'd2, 32'd3, 32'd4: w_class = CL_MULDIV;
        32'd18:              w_class = CL_JR;
        default:             w_class = CL_ALU;
      endcase
    end else begin
      case (w_op_n)
        32'd3, 32'd4, 32'd5: w_class = CL_MULDIV;
        32'd1, 32'd2, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12,
        32'd13, 32'd14, 32'd16, 32'd17, 32'd19:
                             w_class = CL_ALU;
        32'd15:              w_class = CL_LW;
        32'd18:              w_class = CL_SW;
        32'd21:              w_class = CL_JF;
        32'd31:              w_class = CL_SYSCALL;
        32'd32:              w_class = CL_EXEC;
        32'd60:              w_class = CL_J;
        32'd62:              w_class = CL_JAL;
        32'd63:              w_class = CL_HALT;
        default:             w_class = CL_NOP;
      endcase
    end
  end

  // Lowest-index pending line wins.
  always_comb begin
    w_low = '0;
    for (int i = IRQ_LINES - 1; i >= 0; i--) begin
      if (r_pend[i]) w_low = IRQ_ID_W'(i);
    end
  end

  assign w_ack_mask  = IRQ_LINES'(1) << w_low;
  // A line rising during INTR is ORed back after the acknowledged bit is cleared.
  assign w_pend_next = (r_state == S_INTR) ? ((r_pend & ~w_ack_mask) | bus.intr)
                                           : (r_pend | bus.intr);

  // Mode after this cycle. The instruction-boundary decision uses this value so
  // that an exec returning to user mode can be interrupted immediately.
  always_comb begin
    w_user_next = r_user;
    if (r_state == S_EXEC && r_class == CL_SYSCALL) w_user_next = 1'b0;
    if (r_state == S_EXEC && r_class == CL_EXEC)    w_user_next = 1'b1;
    if (r_state == S_INTR)                          w_user_next = 1'b0;
  end

  assign w_done = ((r_pend != '0) && w_user_next) ? S_INTR : S_BUSCA;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_BUSCA;
      r_class <= CL_NOP;
      r_rtype <= 1'b0;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_user  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pend_next;
      r_user  <= w_user_next;
      if (r_state == S_DECOD) begin
        r_class <= w_class;
        r_rtype <= w_rtype;
      end
      if (r_state == S_EXEC) begin
        r_cnt <= '0;
      end else if (r_state == S_ESPERA) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_irWrite      = 1'b0;
    w_pcWrite      = 1'b0;
    w_pcSource     = 2'd0;
    w_regWrite     = 1'b0;
    w_regDest      = 2'd0;
    w_regWrtSelect = 2'd0;
    w_memWrite     = 1'b0;
    w_aluStart     = 1'b0;
    w_inta         = 1'b0;
    w_intrId       = '0;
    w_isHalt       = 1'b0;
    case (r_state)
      S_BUSCA: begin
        w_irWrite = 1'b1;
        w_next    = S_DECOD;
      end
      S_DECOD: begin
        w_next = (w_class == CL_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        w_next = w_done;
        case (r_class)
          CL_ALU: begin
            w_aluStart = 1'b1;
            w_next     = S_ESCRITA;
          end
          CL_MULDIV: begin
            w_aluStart = 1'b1;
            w_next     = (MULDIV_LAT > 1) ? S_ESPERA : S_ESCRITA;
          end
          CL_LW, CL_SW: begin
            w_aluStart = 1'b1;
            w_next     = S_MEM;
          end
          CL_JR: begin
            w_aluStart = 1'b1;
            w_pcWrite  = 1'b1;
            w_pcSource = 2'd2;
          end
          CL_JF: begin
            w_aluStart = 1'b1;
            w_pcWrite  = 1'b1;
            // Only output that follows a live input within the cycle.
            w_pcSource = bus.isFalse ? 2'd1 : 2'd0;
          end
          CL_J: begin
            w_pcWrite  = 1'b1;
            w_pcSource = 2'd1;
          end
          CL_JAL: begin
            w_pcWrite      = 1'b1;
            w_pcSource     = 2'd1;
            w_regWrite     = 1'b1;
            w_regDest      = 2'd2;
            w_regWrtSelect = 2'd2;
          end
          CL_SYSCALL: begin
            w_pcWrite  = 1'b1;
            w_pcSource = 2'd3;
          end
          CL_EXEC: begin
            w_pcWrite  = 1'b1;
            w_pcSource = 2'd1;
          end
          default: begin
            w_pcWrite  = 1'b1;
            w_pcSource = 2'd0;
          end
        endcase
      end
      S_ESPERA: begin
        if (r_cnt == CNT_LAST) w_next = S_ESCRITA;
      end
      S_MEM: begin
        if (r_class == CL_SW) begin
          w_memWrite = 1'b1;
          w_pcWrite  = 1'b1;
          w_next     = w_done;
        end else begin
          w_next = S_ESCRITA;
        end
      end
      S_ESCRITA: begin
        w_regWrite     = 1'b1;
        w_pcWrite      = 1'b1;
        w_regDest      = r_rtype ? 2'd0 : 2'd1;
        w_regWrtSelect = (r_class == CL_LW) ? 2'd1 : 2'd0;
        w_next         = w_done;
      end
      S_INTR: begin
        w_inta         = 1'b1;
        w_intrId       = w_low;
        w_pcWrite      = 1'b1;
        w_pcSource     = 2'd3;
        w_regWrite     = 1'b1;
        w_regDest      = 2'd2;
        w_regWrtSelect = 2'd2;
        w_next         = S_BUSCA;
      end
      S_HALT: begin
        w_isHalt = 1'b1;
        w_next   = S_HALT;
      end
      default: w_next = S_BUSCA;
    endcase
  end

  // The reset state is BUSCA, but no fetch may be issued while reset is held.
  assign bus.irWrite      = w_irWrite & ~reset;
  assign bus.pcWrite      = w_pcWrite;
  assign bus.pcSource     = w_pcSource;
  assign bus.regWrite     = w_regWrite;
  assign bus.regDest      = w_regDest;
  assign bus.regWrtSelect = w_regWrtSelect;
  assign bus.memWrite     = w_memWrite;
  assign bus.aluStart     = w_aluStart;
  assign bus.inta         = w_inta;
  assign bus.intrId       = w_intrId;
  assign bus.isHalt       = w_isHalt;
  assign bus.userMode     = r_user;
  assign bus.kernelMode   = ~r_user;
  assign bus.busy         = (r_state != S_BUSCA) && (r_state != S_HALT);
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_unidade_de_controle_multiciclo.sv
module tb_unidade_de_controle_multiciclo;
  localparam int OPW = 6, FNW = 6, LAT = 4, NIRQ = 4, IDW = 2;
  localparam int VW = 18;
  // Bit positions inside an output snapshot.
  localparam int B_IR = 17, B_PW = 16, B_PS = 14, B_RW = 13, B_RD = 11;
  localparam int B_RS = 9, B_MW = 8, B_AS = 7, B_IA = 6, B_ID = 4;
  localparam int B_US = 3, B_KS = 2, B_HA = 1, B_BU = 0;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  unidade_de_controle_multiciclo_if #(
    .OP_WIDTH(OPW), .FUNC_WIDTH(FNW), .IRQ_LINES(NIRQ), .IRQ_ID_W(IDW)
  ) bus ();

  logic [2:0] dbg_state;

  unidade_de_controle_multiciclo #(
    .OP_WIDTH(OPW), .FUNC_WIDTH(FNW), .MULDIV_LAT(LAT),
    .IRQ_LINES(NIRQ), .IRQ_ID_W(IDW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  logic [VW-1:0] dut_v;
  assign dut_v = {bus.irWrite, bus.pcWrite, bus.pcSource, bus.regWrite,
                  bus.regDest, bus.regWrtSelect, bus.memWrite, bus.aluStart,
                  bus.inta, bus.intrId, bus.userMode, bus.kernelMode,
                  bus.isHalt, bus.busy};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] trace[64];
  int last_n;
  logic m_user;
  logic [NIRQ-1:0] m_pend;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] mk(input bit ir, input bit pw, input int ps,
                                       input bit rw, input int rd, input int rs,
                                       input bit mw, input bit as, input bit ia,
                                       input int id, input bit us, input bit ha,
                                       input bit bu);
    return {ir, pw, 2'(ps), rw, 2'(rd), 2'(rs), mw, as, ia, 2'(id), us, ~us, ha, bu};
  endfunction

  // Compare process: every queued expectation is checked on a falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        logic [VW-1:0] e;
        e = exp_q.pop_front();
        chk("cycle_outputs", 32'(dut_v), 32'(e));
      end
    end
  end

  // ---------------- model + driver ----------------
  // Builds the expected per-cycle outputs of one instruction (plus a following
  // interrupt entry if one is due), queues them and runs the clock through it.
  // cut > 0 stops after that many cycles without closing the instruction.
  task automatic run(input int o, input int f, input bit isf,
                     input logic [NIRQ-1:0] irq, input int cut);
    logic [VW-1:0] seq[$];
    bit rt, us_after;
    bit u;
    int low, n;
    logic [NIRQ-1:0] pend;
    bus.op = OPW'(o);
    bus.func = FNW'(f);
    bus.isFalse = isf;
    bus.intr = irq;
    rt = (o == 0);
    u = m_user;
    us_after = m_user;
    seq.push_back(mk(1,0,0,0,0,0,0,0,0,0,u,0,0));           // fetch
    seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,u,0,1));           // decode
    if (o == 63) begin
      repeat (20) seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,u,1,0));
    end else begin
      if ((rt && (f == 2 || f == 3 || f == 4)) || (!rt && o >= 3 && o <= 5)) begin
        seq.push_back(mk(0,0,0,0,0,0,0,1,0,0,u,0,1));
        repeat (LAT - 1) seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,u,0,1));
        seq.push_back(mk(0,1,0,1,rt ? 0 : 1,0,0,0,0,0,u,0,1));
      end else if (rt && f == 18) begin
        seq.push_back(mk(0,1,2,0,0,0,0,1,0,0,u,0,1));
      end else if (rt || (o inside {1, 2, [6:14], 16, 17, 19})) begin
        seq.push_back(mk(0,0,0,0,0,0,0,1,0,0,u,0,1));
        seq.push_back(mk(0,1,0,1,rt ? 0 : 1,0,0,0,0,0,u,0,1));
      end else begin
        case (o)
          15: begin
            seq.push_back(mk(0,0,0,0,0,0,0,1,0,0,u,0,1));
            seq.push_back(mk(0,0,0,0,0,0,0,0,0,0,u,0,1));
            seq.push_back(mk(0,1,0,1,1,1,0,0,0,0,u,0,1));
          end
          18: begin
            seq.push_back(mk(0,0,0,0,0,0,0,1,0,0,u,0,1));
            seq.push_back(mk(0,1,0,0,0,0,1,0,0,0,u,0,1));
          end
          21: seq.push_back(mk(0,1,isf ? 1 : 0,0,0,0,0,1,0,0,u,0,1));
          60: seq.push_back(mk(0,1,1,0,0,0,0,0,0,0,u,0,1));
          62: seq.push_back(mk(0,1,1,1,2,2,0,0,0,0,u,0,1));
          31: begin
            seq.push_back(mk(0,1,3,0,0,0,0,0,0,0,u,0,1));
            us_after = 1'b0;
          end
          32: begin
            seq.push_back(mk(0,1,1,0,0,0,0,0,0,0,u,0,1));
            us_after = 1'b1;
          end
          default: seq.push_back(mk(0,1,0,0,0,0,0,0,0,0,u,0,1));
        endcase
      end
      if (cut == 0) begin
        pend = m_pend | irq;
        if (us_after && pend != '0) begin
          low = 0;
          for (int i = NIRQ - 1; i >= 0; i--) if (pend[i]) low = i;
          seq.push_back(mk(0,1,3,1,2,2,0,0,1,low,1,0,1));
          m_pend = (pend & ~(NIRQ'(1) << low)) | irq;
          m_user = 1'b0;
        end else begin
          m_pend = pend;
          m_user = us_after;
        end
      end
    end
    n = (cut > 0) ? cut : seq.size();
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
    last_n = n;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      trace[i] = dut_v;
      @(posedge clock);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [VW-1:0] rst_v;
  logic [VW-1:0] strobe_m;

  initial begin
    rst_v = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);
    strobe_m = '0;
    strobe_m[B_IR] = 1'b1; strobe_m[B_PW] = 1'b1; strobe_m[B_RW] = 1'b1;
    strobe_m[B_MW] = 1'b1; strobe_m[B_AS] = 1'b1; strobe_m[B_IA] = 1'b1;
    m_user = 1'b0;
    m_pend = '0;
    reset = 1'b1;
    bus.op = '0; bus.func = '0; bus.isFalse = 1'b0; bus.intr = '0;
    exp_q.push_back(rst_v);
    @(negedge clock);
    chk("rst_irWrite", 32'(bus.irWrite), 0);
    chk("rst_kernel", 32'(bus.kernelMode), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    @(posedge clock);
    #1 reset = 1'b0;

    run(1, 0, 0, 4'b0000, 0);                 // addi
    chk("addi_len", last_n, 4);
    chk("addi_c1_irWrite", 32'(trace[0][B_IR]), 1);
    chk("addi_c3_aluStart", 32'(trace[2][B_AS]), 1);
    chk("addi_c4_regWrite", 32'(trace[3][B_RW]), 1);
    chk("addi_c4_regDest", 32'(trace[3][B_RD +: 2]), 1);
    chk("addi_c4_pcWrite", 32'(trace[3][B_PW]), 1);

    run(0, 0, 0, 4'b0000, 0);                 // R-type ALU
    chk("radd_c4_regDest", 32'(trace[3][B_RD +: 2]), 0);

    run(0, 2, 0, 4'b0000, 0);                 // mul
    chk("mul_len", last_n, 7);
    chk("mul_c7_regWrite", 32'(trace[6][B_RW]), 1);
    for (int i = 3; i <= 5; i++) chk("mul_wait_quiet", 32'(trace[i] & strobe_m), 0);

    run(4, 0, 0, 4'b0000, 0);                 // div immediate
    chk("divi_len", last_n, 7);

    run(15, 0, 0, 4'b0000, 0);                // lw
    chk("lw_len", last_n, 5);
    chk("lw_c5_wrtsel", 32'(trace[4][B_RS +: 2]), 1);

    run(18, 0, 0, 4'b0000, 0);                // sw
    chk("sw_len", last_n, 4);
    chk("sw_c4_memWrite", 32'(trace[3][B_MW]), 1);
    chk("sw_c3_memWrite", 32'(trace[2][B_MW]), 0);

    run(21, 0, 0, 4'b0000, 0);                // jf, not taken
    chk("jf0_pcSource", 32'(trace[2][B_PS +: 2]), 0);
    run(21, 0, 1, 4'b0000, 0);                // jf, taken
    chk("jf1_pcSource", 32'(trace[2][B_PS +: 2]), 1);
    chk("jf_len", last_n, 3);

    run(62, 0, 0, 4'b0000, 0);                // jal
    chk("jal_regDest", 32'(trace[2][B_RD +: 2]), 2);
    chk("jal_wrtsel", 32'(trace[2][B_RS +: 2]), 2);

    run(60, 0, 0, 4'b0000, 0);                // j
    run(0, 18, 0, 4'b0000, 0);                // jr
    chk("jr_pcSource", 32'(trace[2][B_PS +: 2]), 2);
    run(40, 0, 0, 4'b0000, 0);                // unlisted -> nop
    run(31, 0, 0, 4'b0000, 0);                // syscall in kernel mode

    // Interrupts accumulate in kernel mode, then are taken after exec.
    run(40, 0, 0, 4'b1010, 0);
    chk("kernel_no_intr_len", last_n, 3);
    run(32, 0, 0, 4'b0000, 0);
    chk("exec_intr_len", last_n, 4);
    chk("intr1_inta", 32'(trace[3][B_IA]), 1);
    chk("intr1_id", 32'(trace[3][B_ID +: 2]), 1);
    chk("intr1_pcSource", 32'(trace[3][B_PS +: 2]), 3);
    run(32, 0, 0, 4'b0000, 0);
    chk("after_intr_kernel", 32'(trace[0][B_KS]), 1);
    chk("intr2_id", 32'(trace[3][B_ID +: 2]), 3);
    run(32, 0, 0, 4'b0000, 0);
    chk("exec_no_pend_len", last_n, 3);
    run(1, 0, 0, 4'b0000, 0);                 // addi in user mode
    chk("user_mode", 32'(trace[1][B_US]), 1);
    run(32, 0, 0, 4'b0001, 0);                // line 0 held through INTR
    chk("held_intr_id", 32'(trace[3][B_ID +: 2]), 0);
    run(32, 0, 0, 4'b0000, 0);                // re-pended line taken again
    chk("repend_inta", 32'(trace[3][B_IA]), 1);

    // Halt ignores interrupts; only reset leaves it.
    run(63, 0, 0, 4'b1111, 0);
    chk("halt_isHalt", 32'(trace[21][B_HA]), 1);
    chk("halt_busy", 32'(trace[21][B_BU]), 0);
    #3 reset = 1'b1;
    #1 chk("halt_reset_now", 32'(dut_v), 32'(rst_v));
    bus.intr = '0;
    @(posedge clock);
    #1 reset = 1'b0;
    m_user = 1'b0;
    m_pend = '0;

    // Async reset in the middle of the mul stretch.
    run(0, 2, 0, 4'b0000, 4);
    #3 reset = 1'b1;
    #1 chk("espera_reset_now", 32'(dut_v), 32'(rst_v));
    @(posedge clock);
    #1 reset = 1'b0;
    m_user = 1'b0;
    m_pend = '0;
    run(1, 0, 0, 4'b0000, 0);
    chk("post_reset_addi_len", last_n, 4);

    @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
